// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Entry layout pairs each fetched word with the PC it came from.
package fetch_pkg;

   localparam int P_ADDR_W = 32;
   localparam int P_DATA_W = 32;
   localparam logic [P_ADDR_W-1:0] P_RESET_PC = '0;

   typedef struct packed {
      logic [P_ADDR_W-1:0] pc;
      logic [P_DATA_W-1:0] inst;
   } fetch_entry_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage.
// Power-of-two depth so pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_din,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_dout,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [clog2(DEPTH):0] o_count
);

   localparam int PW = clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // flush wins over both push and pop in the same cycle
   assign w_push  = i_push && !i_flush;
   assign w_pop   = i_pop && !i_flush && !o_empty;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_count <= r_count + {{PW{1'b0}}, w_push}
                            - {{PW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(w_push && o_full && !w_pop)
   );

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited imem requests, PC queue, prefetch buffer.
// Define FETCH_BYPASS_EN to forward a response to decode when the buffer is empty.
module inst_fetch
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = P_ADDR_W,
   parameter int                DATA_W   = P_DATA_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(P_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc
);

   localparam int PW = clog2(DEPTH);
   localparam int EW = $bits(fetch_entry_t);
   localparam logic [PW+1:0] CREDIT_LIM = (PW+2)'(DEPTH);

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [PW:0]       r_drop;

   logic              w_pcq_full;
   logic              w_pcq_empty;
   logic [PW:0]       w_pcq_count;
   logic [ADDR_W-1:0] w_rsp_pc;

   logic              w_buf_full;
   logic              w_buf_empty;
   logic [PW:0]       w_buf_count;
   logic [EW-1:0]     w_head_bits;
   fetch_entry_t      w_head;
   fetch_entry_t      w_wr_entry;

   logic              w_credit;
   logic              w_req_fire;
   logic              w_rsp;
   logic              w_rsp_drop;
   logic              w_rsp_keep;
   logic              w_bypass;
   logic              w_buf_push;
   logic              w_buf_pop;

   // the PC queue count is exactly the number of outstanding requests
   assign w_credit = ({1'b0, w_pcq_count} + {1'b0, w_buf_count})
                     < CREDIT_LIM;

   assign imem_req_valid = reset && w_credit && !w_pcq_full
                           && !redirect_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // a response with nothing outstanding (e.g. left over from before reset) is ignored
   assign w_rsp      = imem_rsp_valid && !w_pcq_empty;
   assign w_rsp_drop = (r_drop != '0);
   assign w_rsp_keep = w_rsp && !w_rsp_drop && !redirect_valid;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_buf_empty && out_ready && w_rsp_keep;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_buf_push = w_rsp_keep && !w_bypass;
   assign w_buf_pop  = out_ready && !w_buf_empty;

   assign w_wr_entry.pc   = w_rsp_pc;
   assign w_wr_entry.inst = imem_rsp_data;
   assign w_head          = fetch_entry_t'(w_head_bits);

   assign out_valid = !w_buf_empty || w_bypass;
   assign out_inst  = w_bypass    ? imem_rsp_data :
                      w_buf_empty ? '0 : w_head.inst;
   assign out_pc    = w_bypass    ? w_rsp_pc :
                      w_buf_empty ? '0 : w_head.pc;

   fetch_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_pc_q (
      .clk     (clk),
      .rst_n   (reset),
      .i_flush (1'b0),
      .i_push  (w_req_fire),
      .i_din   (r_fetch_pc),
      .i_pop   (w_rsp),
      .o_dout  (w_rsp_pc),
      .o_full  (w_pcq_full),
      .o_empty (w_pcq_empty),
      .o_count (w_pcq_count)
   );

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst_n   (reset),
      .i_flush (redirect_valid),
      .i_push  (w_buf_push),
      .i_din   (w_wr_entry),
      .i_pop   (w_buf_pop),
      .o_dout  (w_head_bits),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_drop     <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         r_drop     <= w_pcq_count - {{PW{1'b0}}, w_rsp};
      end else begin
         if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
         if (w_rsp && w_rsp_drop) r_drop <= r_drop - {{PW{1'b0}}, 1'b1};
      end
   end

   a_no_lost_rsp: assert property (
      @(posedge clk) disable iff (!reset)
      !(w_buf_push && w_buf_full && !w_buf_pop)
   );

endmodule
